mem_wb_pipe_stage: RTL and testbench
====================================

// Module: mem_wb_pipe_stage
// PURPOSE
//  Parametrised MEM->WB pipeline stage with valid/ready handshake. A 2-entry skid buffer gives full throughput, registered in_ready and lossless back-pressure.
//  Carries memory read data, ALU result, write-back register index and WB control bits to the register-file write port.
//  Adds stall, flush and r0 write suppression; the stage is no longer a bare free-running latch.
// PARAMETERS
//  DATA_W      32  width of memory data and ALU result
//  REG_ADDR_W  5   width of write-back register index
// PORTS
//  clk              in   1           single clock; all state updates on posedge
//  rst_n            in   1           synchronous, active-low reset
//  flush            in   1           discard all held entries and the current input
//  in_valid         in   1           MEM stage presents a transfer
//  in_ready         out  1           stage can accept; registered
//  in_mem_data      in   DATA_W      data-memory read value
//  in_alu_data      in   DATA_W      ALU result / address
//  in_wb_reg        in   REG_ADDR_W  destination register index
//  in_reg_write     in   1           write-back enable
//  in_mem_to_reg    in   1           1 = write mem data, 0 = write ALU data
//  out_valid        out  1           WB transfer present
//  out_ready        in   1           WB stage consumes
//  out_mem_data     out  DATA_W      held mem data
//  out_alu_data     out  DATA_W      held ALU data
//  out_wb_reg       out  REG_ADDR_W  held destination index
//  out_reg_write    out  1           held write enable, forced 0 when out_valid=0
//  out_mem_to_reg   out  1           held select
//  out_wb_data      out  DATA_W      present only with MEMWB_WBMUX_EN
// BEHAVIOUR
//  Handshakes:
//  - Transfer in on in_valid&in_ready; transfer out on out_valid&out_ready.
//  - in_valid does not depend on in_ready.
//  Reset (rst_n=0 at posedge):
//  - Both entries invalid; all payload outputs 0; out_valid=0; in_ready=1 on the next cycle.
//  State machine (main=output reg, skid=overflow reg):
//  - EMPTY -in-> ONE.
//  - ONE: in&out -> ONE (main reloads); in&!out -> TWO (input goes to skid, in_ready falls next cycle); out&!in -> EMPTY.
//  - TWO: out -> ONE (skid moves to main, in_ready=1 next cycle); !out -> TWO (hold, in_ready=0).
//  Timing:
//  - Latency is 1 cycle in->out when empty. Throughput is 1 transfer/cycle with out_ready held high.
//  - in_ready = !skid_valid, registered. An in_valid seen while in_ready=0 is not accepted; the source must hold.
//  - Payload outputs are stable while out_valid&!out_ready.
//  Write suppression:
//  - Entries captured with in_wb_reg==0 store reg_write=0 (r0 hardwired).
//  - out_reg_write = main.reg_write & out_valid.
//  Flush:
//  - Priority rst_n > flush > handshake.
//  - Flush at posedge: both entries invalid, the simultaneous input is dropped even if accepted, in_ready=1 next cycle.
//  - Payload registers may retain stale data; only valid is cleared.
//  Reset asserted mid-transfer behaves as flush plus payload zeroing.
// CONFIGURATION
//  MEMWB_WBMUX_EN defined:
//  - out_wb_data = out_mem_to_reg ? out_mem_data : out_alu_data.
//  - The mux is combinational from the main entry and reads 0 after reset.
//  Not defined: out_wb_data port absent; the WB stage performs the select.
// STRUCTURE
//  Package mips_pkg:
//  - DATA_W and REG_ADDR_W defaults, REG_ZERO constant.
//  - memwb_payload_t packed struct {mem_data, alu_data, wb_reg, reg_write, mem_to_reg}.
//  - Skid state enum {EMPTY, ONE, TWO}.
//  Sub-module pipe_skid_buf (generic WIDTH, valid/ready, flush):
//  - Instantiated once on the packed payload.
//  - r0 masking and the WB mux stay in this wrapper.
// TESTING
//  1 Reset: rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, out_reg_write=0, payload 0; in_ready=1 after release.
//  2 Streaming: out_ready=1, 8 back-to-back transfers alu=0x10..0x17 -> same order 1 cycle later, no bubbles.
//  3 Back-pressure: out_ready=0 while sending A=0xAAAA0000, B=0xBBBB0000 -> in_ready=0 after B; out holds A stable.
//     Then out_ready=1 -> A, then B, no loss or duplication.
//  4 Flush: entries in TWO plus simultaneous in_valid C, flush=1 -> next cycle out_valid=0, in_ready=1, C never appears.
//  5 r0 suppression: wb_reg=0, reg_write=1, alu=0x1234 -> out_valid=1, out_reg_write=0, out_alu_data=0x1234.
//  6 MEMWB_WBMUX_EN: mem=0xDEAD0001, alu=0x00000002.
//     mem_to_reg=1 -> out_wb_data=0xDEAD0001; mem_to_reg=0 -> 0x00000002.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MEM->WB types: default widths, r0 index, payload layout and skid-buffer state encoding.
package mips_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;

  localparam logic [REG_ADDR_W_DEF-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [DATA_W_DEF-1:0]     mem_data;
    logic [DATA_W_DEF-1:0]     alu_data;
    logic [REG_ADDR_W_DEF-1:0] wb_reg;
    logic                      reg_write;
    logic                      mem_to_reg;
  } memwb_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic 2-entry skid buffer: 1-cycle latency, full throughput, registered inReady.
// Back-pressure parks one extra beat in skid; flush drops both entries and the current input.
module pipe_skid_buf
  import mips_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inData,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outData
);

  skid_state_t      state, nextState;
  logic [WIDTH-1:0] mainData, skidData;
  logic             loadMain, loadSkid, moveSkid;
  logic             inFire, outFire;

  assign outValid = (state != EMPTY);
  assign outData  = mainData;
  assign inFire   = inValid & inReady;
  assign outFire  = outValid & outReady;

  always_comb begin
    nextState = state;
    loadMain  = 1'b0;
    loadSkid  = 1'b0;
    moveSkid  = 1'b0;
    case (state)
      EMPTY: begin
        if (inFire) begin
          nextState = ONE;
          loadMain  = 1'b1;
        end
      end
      ONE: begin
        if (inFire && outFire) begin
          loadMain = 1'b1;
        end else if (inFire) begin
          nextState = TWO;
          loadSkid  = 1'b1;
        end else if (outFire) begin
          nextState = EMPTY;
        end
      end
      TWO: begin
        // inReady is low here, so only the drain path exists
        if (outFire) begin
          nextState = ONE;
          moveSkid  = 1'b1;
        end
      end
      default: nextState = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= EMPTY;
      inReady  <= 1'b1;
      mainData <= '0;
      skidData <= '0;
    end else if (flush) begin
      // payload is left stale; only occupancy is cleared
      state   <= EMPTY;
      inReady <= 1'b1;
    end else begin
      state   <= nextState;
      inReady <= (nextState != TWO);
      if (loadMain) begin
        mainData <= inData;
      end else if (moveSkid) begin
        mainData <= skidData;
      end
      if (loadSkid) begin
        skidData <= inData;
      end
    end
  end

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB stage over pipe_skid_buf: 1-cycle latency, lossless valid/ready, r0 write suppression.
// Optional MEMWB_WBMUX_EN adds out_wb_data, the combinational write-back select from the main entry.
module mem_wb_pipe_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     in_mem_data,
  input  logic [DATA_W-1:0]     in_alu_data,
  input  logic [REG_ADDR_W-1:0] in_wb_reg,
  input  logic                  in_reg_write,
  input  logic                  in_mem_to_reg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_mem_data,
  output logic [DATA_W-1:0]     out_alu_data,
  output logic [REG_ADDR_W-1:0] out_wb_reg,
  output logic                  out_reg_write,
  output logic                  out_mem_to_reg
`ifdef MEMWB_WBMUX_EN
  ,
  output logic [DATA_W-1:0]     out_wb_data
`endif
);

  // Same field order as memwb_payload_t, sized by this instance's parameters
  typedef struct packed {
    logic [DATA_W-1:0]     mem_data;
    logic [DATA_W-1:0]     alu_data;
    logic [REG_ADDR_W-1:0] wb_reg;
    logic                  reg_write;
    logic                  mem_to_reg;
  } payload_t;

  payload_t inPayload, outPayload;

  always_comb begin
    inPayload            = '0;
    inPayload.mem_data   = in_mem_data;
    inPayload.alu_data   = in_alu_data;
    inPayload.wb_reg     = in_wb_reg;
    // r0 is hardwired, so its write enable is dropped at capture
    inPayload.reg_write  = in_reg_write & (in_wb_reg != REG_ADDR_W'(REG_ZERO));
    inPayload.mem_to_reg = in_mem_to_reg;
  end

  pipe_skid_buf #(
    .WIDTH($bits(payload_t))
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .inValid (in_valid),
    .inReady (in_ready),
    .inData  (inPayload),
    .outValid(out_valid),
    .outReady(out_ready),
    .outData (outPayload)
  );

  assign out_mem_data   = outPayload.mem_data;
  assign out_alu_data   = outPayload.alu_data;
  assign out_wb_reg     = outPayload.wb_reg;
  assign out_reg_write  = outPayload.reg_write & out_valid;
  assign out_mem_to_reg = outPayload.mem_to_reg;

`ifdef MEMWB_WBMUX_EN
  assign out_wb_data = outPayload.mem_to_reg ? outPayload.mem_data : outPayload.alu_data;
`endif

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Scoreboard bench for mem_wb_pipe_stage: expected beats queued on input handshake, compared on output handshake.
module tb_mem_wb_pipe_stage;
  import mips_pkg::*;

  localparam int DW = DATA_W_DEF;
  localparam int RW = REG_ADDR_W_DEF;

  logic          clk = 1'b0;
  logic          rst_n, flush;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_mem_data, in_alu_data;
  logic [RW-1:0] in_wb_reg;
  logic          in_reg_write, in_mem_to_reg;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_mem_data, out_alu_data;
  logic [RW-1:0] out_wb_reg;
  logic          out_reg_write, out_mem_to_reg;
`ifdef MEMWB_WBMUX_EN
  logic [DW-1:0] out_wb_data;
`endif

  int checkCount = 0;
  int errorCount = 0;
  int popCount   = 0;
  memwb_payload_t expQ[$];

  always #5 clk = ~clk;

  mem_wb_pipe_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_mem_data   (in_mem_data),
    .in_alu_data   (in_alu_data),
    .in_wb_reg     (in_wb_reg),
    .in_reg_write  (in_reg_write),
    .in_mem_to_reg (in_mem_to_reg),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_mem_data  (out_mem_data),
    .out_alu_data  (out_alu_data),
    .out_wb_reg    (out_wb_reg),
    .out_reg_write (out_reg_write),
    .out_mem_to_reg(out_mem_to_reg)
`ifdef MEMWB_WBMUX_EN
    ,
    .out_wb_data   (out_wb_data)
`endif
  );

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: inputs are stable between negedge and the next posedge
  always @(negedge clk) begin
    memwb_payload_t e;
    if (rst_n !== 1'b1 || flush === 1'b1) begin
      expQ.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (expQ.size() == 0) begin
          checkVal("unexpected_out", {63'd0, out_valid}, 64'd0);
        end else begin
          e = expQ.pop_front();
          popCount++;
          checkVal("sb_mem_data", {32'd0, out_mem_data}, {32'd0, e.mem_data});
          checkVal("sb_alu_data", {32'd0, out_alu_data}, {32'd0, e.alu_data});
          checkVal("sb_wb_reg", {59'd0, out_wb_reg}, {59'd0, e.wb_reg});
          checkVal("sb_reg_write", {63'd0, out_reg_write}, {63'd0, e.reg_write});
          checkVal("sb_mem_to_reg", {63'd0, out_mem_to_reg}, {63'd0, e.mem_to_reg});
`ifdef MEMWB_WBMUX_EN
          checkVal("sb_wb_data", {32'd0, out_wb_data},
                   {32'd0, (e.mem_to_reg ? e.mem_data : e.alu_data)});
`endif
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        e.mem_data   = in_mem_data;
        e.alu_data   = in_alu_data;
        e.wb_reg     = in_wb_reg;
        e.reg_write  = in_reg_write && (in_wb_reg != 5'd0);
        e.mem_to_reg = in_mem_to_reg;
        expQ.push_back(e);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] mem, input logic [31:0] alu,
                       input logic [4:0] r, input logic rw, input logic m2r);
    in_valid      = v;
    in_mem_data   = mem;
    in_alu_data   = alu;
    in_wb_reg     = r;
    in_reg_write  = rw;
    in_mem_to_reg = m2r;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int p0;
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b1, 32'hFFFF_0000, 32'hEEEE_0000, 5'd3, 1'b1, 1'b1);

    // Reset held two cycles with in_valid asserted
    tick;
    tick;
    @(negedge clk);
    checkVal("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkVal("rst_reg_write", {63'd0, out_reg_write}, 64'd0);
    checkVal("rst_alu_data", {32'd0, out_alu_data}, 64'd0);
    checkVal("rst_mem_data", {32'd0, out_mem_data}, 64'd0);
    checkVal("rst_wb_reg", {59'd0, out_wb_reg}, 64'd0);
    checkVal("rst_mem_to_reg", {63'd0, out_mem_to_reg}, 64'd0);
`ifdef MEMWB_WBMUX_EN
    checkVal("rst_wb_data", {32'd0, out_wb_data}, 64'd0);
`endif
    tick;
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    checkVal("rst_in_ready", {63'd0, in_ready}, 64'd1);
    tick;

    // Streaming: 8 back-to-back beats with out_ready high
    out_ready = 1'b1;
    p0 = popCount;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h100 + 32'(i), 32'h10 + 32'(i), 5'(i + 1), 1'b1, 1'(i));
      @(negedge clk);
      checkVal("stream_in_ready", {63'd0, in_ready}, 64'd1);
      if (i > 0) begin
        checkVal("stream_out_valid", {63'd0, out_valid}, 64'd1);
        checkVal("stream_order", {32'd0, out_alu_data}, 64'h10 + 64'(i - 1));
      end
      tick;
    end
    in_valid = 1'b0;
    @(negedge clk);
    checkVal("stream_last", {32'd0, out_alu_data}, 64'h17);
    tick;
    @(negedge clk);
    checkVal("stream_idle", {63'd0, out_valid}, 64'd0);
    checkVal("stream_count", 64'(popCount - p0), 64'd8);
    tick;

    // Back-pressure: A then B with out_ready low, then drain
    out_ready = 1'b0;
    p0 = popCount;
    drive(1'b1, 32'h0000_00A1, 32'hAAAA_0000, 5'd2, 1'b1, 1'b0);
    @(negedge clk);
    checkVal("bp_rdy_a", {63'd0, in_ready}, 64'd1);
    tick;
    drive(1'b1, 32'h0000_00B1, 32'hBBBB_0000, 5'd3, 1'b0, 1'b1);
    @(negedge clk);
    checkVal("bp_rdy_b", {63'd0, in_ready}, 64'd1);
    tick;
    // A held source beat that must not be taken while in_ready is low
    drive(1'b1, 32'h0000_00F1, 32'hFFFF_1111, 5'd9, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkVal("bp_rdy_low", {63'd0, in_ready}, 64'd0);
      checkVal("bp_out_valid", {63'd0, out_valid}, 64'd1);
      checkVal("bp_hold_a", {32'd0, out_alu_data}, 64'hAAAA_0000);
      tick;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checkVal("bp_drain_a", {32'd0, out_alu_data}, 64'hAAAA_0000);
    tick;
    @(negedge clk);
    checkVal("bp_drain_b", {32'd0, out_alu_data}, 64'hBBBB_0000);
    checkVal("bp_rdy_back", {63'd0, in_ready}, 64'd1);
    tick;
    @(negedge clk);
    checkVal("bp_empty", {63'd0, out_valid}, 64'd0);
    checkVal("bp_count", 64'(popCount - p0), 64'd2);
    tick;

    // Flush with both entries full and a simultaneous input C
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_00D1, 32'h0000_000D, 5'd4, 1'b1, 1'b0);
    tick;
    drive(1'b1, 32'h0000_00E1, 32'h0000_000E, 5'd5, 1'b1, 1'b0);
    tick;
    drive(1'b1, 32'h0000_00C1, 32'h0000_000C, 5'd6, 1'b1, 1'b0);
    flush = 1'b1;
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkVal("flush2_out_valid", {63'd0, out_valid}, 64'd0);
    checkVal("flush2_in_ready", {63'd0, in_ready}, 64'd1);
    checkVal("flush2_reg_write", {63'd0, out_reg_write}, 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      @(negedge clk);
      checkVal("flush2_no_c", {63'd0, out_valid}, 64'd0);
    end
    tick;

    // Flush with one entry while C is actually accepted
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_00D2, 32'h0000_00D2, 5'd4, 1'b1, 1'b0);
    tick;
    drive(1'b1, 32'h0000_00C2, 32'h0000_00C2, 5'd6, 1'b1, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    checkVal("flush1_c_offered", {63'd0, in_ready}, 64'd1);
    tick;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkVal("flush1_no_c", {63'd0, out_valid}, 64'd0);
      tick;
    end

    // r0 write suppression
    drive(1'b1, 32'h0, 32'h0000_1234, 5'd0, 1'b1, 1'b0);
    tick;
    in_valid = 1'b0;
    @(negedge clk);
    checkVal("r0_out_valid", {63'd0, out_valid}, 64'd1);
    checkVal("r0_reg_write", {63'd0, out_reg_write}, 64'd0);
    checkVal("r0_alu_data", {32'd0, out_alu_data}, 64'h1234);
    tick;

`ifdef MEMWB_WBMUX_EN
    drive(1'b1, 32'hDEAD_0001, 32'h0000_0002, 5'd7, 1'b1, 1'b1);
    tick;
    drive(1'b1, 32'hDEAD_0001, 32'h0000_0002, 5'd7, 1'b1, 1'b0);
    @(negedge clk);
    checkVal("wbmux_mem", {32'd0, out_wb_data}, 64'hDEAD_0001);
    tick;
    in_valid = 1'b0;
    @(negedge clk);
    checkVal("wbmux_alu", {32'd0, out_wb_data}, 64'h0000_0002);
    tick;
`endif

    // Reset while an entry is held zeroes the payload
    out_ready = 1'b0;
    drive(1'b1, 32'h0000_5556, 32'h0000_5555, 5'd7, 1'b1, 1'b1);
    tick;
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    @(negedge clk);
    checkVal("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    checkVal("midrst_alu_data", {32'd0, out_alu_data}, 64'd0);
    checkVal("midrst_wb_reg", {59'd0, out_wb_reg}, 64'd0);
    checkVal("midrst_in_ready", {63'd0, in_ready}, 64'd1);
    tick;
    tick;

    checkVal("drain_queue", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
